// File: rtl/stepper_homing_ctrl_pkg.sv
// Shared types and constants for the stepper homing sequencer.
package stepper_pkg;

    localparam int CTRL_W     = 32;
    localparam int SPEED_W    = 8;
    localparam int GOAL_W     = 24;
    localparam int SETTLE_CYC = 16;
    localparam int SETTLE_W   = $clog2(SETTLE_CYC);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SEEK,
        ST_SETTLE,
        ST_ZERO,
        ST_DONE,
        ST_FAULT
    } state_e;

    // Host control word layout: {speed, goal}
    typedef struct packed {
        logic [SPEED_W-1:0] speed;
        logic [GOAL_W-1:0]  goal;
    } ctrl_word_t;

endpackage

// File: rtl/stepper_homing_ctrl_if.sv
// Host/stepper-side signal bundle for stepper_homing_ctrl.
// master drives requests and switch inputs; slave is the homing controller side.
interface stepper_homing_ctrl_if #(
    parameter int N_AXES = 4
);
    import stepper_pkg::*;

    logic                       start;
    logic [N_AXES-1:0]          limit_sw;
    logic [N_AXES*CTRL_W-1:0]   host_ctrl;
    logic [N_AXES-1:0]          homing_en;
    logic [N_AXES-1:0]          axis_zero;
    logic [N_AXES*CTRL_W-1:0]   ctrl_out;
    logic                       busy;
    logic                       done;
    logic                       fault;
    logic [$clog2(N_AXES)-1:0]  fault_axis;

    modport master (
        output start, limit_sw, host_ctrl,
        input  homing_en, axis_zero, ctrl_out, busy, done, fault, fault_axis
    );

    modport slave (
        input  start, limit_sw, host_ctrl,
        output homing_en, axis_zero, ctrl_out, busy, done, fault, fault_axis
    );

endinterface

// File: rtl/stepper_homing_ctrl_limit_debounce.sv
// Per-axis home switch conditioning: 2-flop synchronizer followed by a
// debounce counter that accepts a new level after DEBOUNCE_CYC equal samples.
module limit_debounce #(
    parameter int DEBOUNCE_CYC = 1000
) (
    input  logic clk,
    input  logic reset,
    input  logic raw_i,
    output logic deb_o
);

    localparam int CNT_W = (DEBOUNCE_CYC > 1) ? $clog2(DEBOUNCE_CYC) : 1;

    logic             sync1_q;
    logic             sync2_q;
    logic             deb_q;
    logic [CNT_W-1:0] cnt_q;

    // Bring the asynchronous switch into the clk domain
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
        end else begin
            sync1_q <= raw_i;
            sync2_q <= sync1_q;
        end
    end

    // Count consecutive samples that disagree with the accepted level
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            deb_q <= 1'b0;
            cnt_q <= '0;
        end else if (sync2_q == deb_q) begin
            cnt_q <= '0;
        end else if (cnt_q == CNT_W'(DEBOUNCE_CYC - 1)) begin
            deb_q <= sync2_q;
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_q + CNT_W'(1);
        end
    end

    assign deb_o = deb_q;

endmodule

// File: rtl/stepper_homing_ctrl.sv
// Sequential multi-axis homing controller: seeks each axis to its home switch,
// lets it settle, pulses the position zero, then hands control to the host.
// Optional macro HOMING_TIMEOUT_EN enables the per-axis SEEK timeout and FAULT.
module stepper_homing_ctrl
    import stepper_pkg::*;
#(
    parameter int N_AXES       = 4,
    parameter int DEBOUNCE_CYC = 1000,
    parameter int TIMEOUT_CYC  = 50_000_000
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      start,
    input  logic [N_AXES-1:0]         limit_sw,
    input  logic [N_AXES*CTRL_W-1:0]  host_ctrl,
    output logic [N_AXES-1:0]         homing_en,
    output logic [N_AXES-1:0]         axis_zero,
    output logic [N_AXES*CTRL_W-1:0]  ctrl_out,
    output logic                      busy,
    output logic                      done,
    output logic                      fault,
    output logic [$clog2(N_AXES)-1:0] fault_axis
);

    localparam int              AX_W    = $clog2(N_AXES);
    localparam logic [AX_W-1:0] AX_LAST = AX_W'(N_AXES - 1);

    state_e              state_q;
    logic [AX_W-1:0]     ax_q;
    logic [SETTLE_W-1:0] settle_q;
    logic [N_AXES-1:0]   homing_en_q;
    logic [N_AXES-1:0]   axis_zero_q;
    logic                busy_q;
    logic                done_q;
    logic [N_AXES-1:0]   limit_deb;

`ifdef HOMING_TIMEOUT_EN
    localparam int TMR_W = $clog2(TIMEOUT_CYC + 1);

    logic [TMR_W-1:0] timer_q;
    logic             fault_q;
    logic [AX_W-1:0]  fault_axis_q;
    logic             timeout;

    assign timeout = (timer_q == TMR_W'(TIMEOUT_CYC - 1));
`else
    logic unused_timeout_cfg;

    assign unused_timeout_cfg = ^TIMEOUT_CYC;
`endif

    function automatic logic [N_AXES-1:0] ax_onehot(input logic [AX_W-1:0] a);
        ax_onehot    = '0;
        ax_onehot[a] = 1'b1;
    endfunction

    for (genvar i = 0; i < N_AXES; i++) begin : g_limit
        limit_debounce #(
            .DEBOUNCE_CYC(DEBOUNCE_CYC)
        ) u_deb (
            .clk   (clk),
            .reset (reset),
            .raw_i (limit_sw[i]),
            .deb_o (limit_deb[i])
        );
    end

    // Homing sequencer; outputs are registered alongside the state so each
    // transition loads the output pattern of the state being entered.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            ax_q        <= '0;
            settle_q    <= '0;
            homing_en_q <= '0;
            axis_zero_q <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
`ifdef HOMING_TIMEOUT_EN
            timer_q      <= '0;
            fault_q      <= 1'b0;
            fault_axis_q <= '0;
`endif
        end else begin
            axis_zero_q <= '0;
            unique case (state_q)
                ST_IDLE, ST_DONE, ST_FAULT: begin
                    if (start) begin
                        state_q     <= ST_SEEK;
                        ax_q        <= '0;
                        homing_en_q <= ax_onehot('0);
                        busy_q      <= 1'b1;
                        done_q      <= 1'b0;
`ifdef HOMING_TIMEOUT_EN
                        timer_q      <= '0;
                        fault_q      <= 1'b0;
                        fault_axis_q <= '0;
`endif
                    end
                end
                ST_SEEK: begin
                    // Limit is tested first so it wins over a same-cycle timeout
                    if (limit_deb[ax_q]) begin
                        state_q     <= ST_SETTLE;
                        settle_q    <= '0;
                        homing_en_q <= '0;
                    end
`ifdef HOMING_TIMEOUT_EN
                    else if (timeout) begin
                        state_q      <= ST_FAULT;
                        homing_en_q  <= '0;
                        busy_q       <= 1'b0;
                        fault_q      <= 1'b1;
                        fault_axis_q <= ax_q;
                    end else begin
                        timer_q <= timer_q + TMR_W'(1);
                    end
`endif
                end
                ST_SETTLE: begin
                    if (settle_q == SETTLE_W'(SETTLE_CYC - 1)) begin
                        state_q     <= ST_ZERO;
                        axis_zero_q <= ax_onehot(ax_q);
                    end else begin
                        settle_q <= settle_q + SETTLE_W'(1);
                    end
                end
                ST_ZERO: begin
                    if (ax_q == AX_LAST) begin
                        state_q <= ST_DONE;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                    end else begin
                        state_q     <= ST_SEEK;
                        ax_q        <= ax_q + AX_W'(1);
                        homing_en_q <= ax_onehot(ax_q + AX_W'(1));
`ifdef HOMING_TIMEOUT_EN
                        timer_q <= '0;
`endif
                    end
                end
                default: begin
                    state_q     <= ST_IDLE;
                    homing_en_q <= '0;
                    busy_q      <= 1'b0;
                    done_q      <= 1'b0;
                end
            endcase
        end
    end

    // Host words pass straight through only once homing has completed
    for (genvar i = 0; i < N_AXES; i++) begin : g_ctrl
        ctrl_word_t word;

        assign word = ctrl_word_t'(host_ctrl[i*CTRL_W +: CTRL_W]);
        assign ctrl_out[i*CTRL_W +: CTRL_W] = done_q ? word : '0;
    end

    assign homing_en = homing_en_q;
    assign axis_zero = axis_zero_q;
    assign busy      = busy_q;
    assign done      = done_q;

`ifdef HOMING_TIMEOUT_EN
    assign fault      = fault_q;
    assign fault_axis = fault_axis_q;
`else
    assign fault      = 1'b0;
    assign fault_axis = '0;
`endif

endmodule
